// File: rtl/data_mem_responder.sv
// Data-memory responder: word-organised RAM behind valid/ready request and response channels.
// Performs RV32I byte/half/word loads and stores, LATENCY cycles after the request is accepted.
module data_mem_responder #(
    parameter int NUM_WORDS = 32,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);

    localparam int IDXW = $clog2(NUM_WORDS);
    localparam int CNTW = (LATENCY < 2) ? 1 : $clog2(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CNTW-1:0]   r_cnt;
    logic              r_wr;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [2:0]        r_funct3;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic [31:0]       r_mem [NUM_WORDS];

    logic              w_accept;
    logic              w_access;
    logic              w_a_wr;
    logic [31:0]       w_a_addr;
    logic [31:0]       w_a_wdata;
    logic [2:0]        w_a_funct3;
    logic [IDXW-1:0]   w_idx;
    logic [1:0]        w_lane;
    logic [31:0]       w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic              w_err;
    logic [31:0]       w_load;
    logic [3:0]        w_mask;
    logic [31:0]       w_wrep;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // a responder holding valid keeps its payload stable until that edge.
    assign w_accept = req_valid && req_ready;

    // With single-cycle latency the access happens on the accept edge, straight from the request.
    assign w_a_wr     = (LATENCY == 1) ? req_wr     : r_wr;
    assign w_a_addr   = (LATENCY == 1) ? req_addr   : r_addr;
    assign w_a_wdata  = (LATENCY == 1) ? req_wdata  : r_wdata;
    assign w_a_funct3 = (LATENCY == 1) ? req_funct3 : r_funct3;
    assign w_access   = (LATENCY == 1) ? w_accept
                                       : ((r_state == S_WAIT) && (r_cnt == CNTW'(1)));

    assign w_idx  = w_a_addr[IDXW+1:2];
    assign w_lane = w_a_addr[1:0];
    assign w_word = r_mem[w_idx];
    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];
    assign w_wrep = (w_a_funct3[1:0] == 2'd0) ? {4{w_a_wdata[7:0]}}
                  : (w_a_funct3[1:0] == 2'd1) ? {2{w_a_wdata[15:0]}}
                  : w_a_wdata;

    always_comb begin
        w_byte = w_word[7:0];
        case (w_lane)
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            2'd3:    w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
    end

    always_comb begin
        w_err  = |w_a_addr[31:IDXW+2];
        w_load = 32'd0;
        w_mask = 4'b0000;
        case (w_a_funct3)
            3'd0: begin
                w_load = {{24{w_byte[7]}}, w_byte};
                w_mask = 4'b0001 << w_lane;
            end
            3'd1: begin
                w_err  = w_err || w_lane[0];
                w_load = {{16{w_half[15]}}, w_half};
                w_mask = w_lane[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                w_err  = w_err || (w_lane != 2'd0);
                w_load = w_word;
                w_mask = 4'b1111;
            end
            3'd4: begin
                w_err  = w_err || w_a_wr;
                w_load = {24'd0, w_byte};
            end
            3'd5: begin
                w_err  = w_err || w_lane[0] || w_a_wr;
                w_load = {16'd0, w_half};
            end
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = (LATENCY == 1) ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt == CNTW'(1)) w_next_state = S_RESP;
            S_RESP:  if (resp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == S_IDLE);
        resp_valid = (r_state == S_RESP);
        resp_rdata = (r_state == S_RESP) ? r_rdata : 32'd0;
        resp_err   = (r_state == S_RESP) ? r_err : 1'b0;
        dbg_state  = r_state;
    end

    // Reset wipes the RAM, so a store still waiting in WAIT is simply lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_wr     <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_funct3 <= 3'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            if (w_accept) begin
                r_wr     <= req_wr;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_funct3 <= req_funct3;
                r_cnt    <= CNTW'(LATENCY - 1);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - CNTW'(1);
            end
            if (w_access) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_a_wr) ? 32'd0 : w_load;
                if (w_a_wr && !w_err) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_mask[b]) r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (NUM_WORDS=32, LATENCY=2) with hand-computed expectations.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    data_mem_responder #(.NUM_WORDS(32), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction: drive at negedge, wait (bounded) for the response, check, then accept it.
    task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        @(negedge clk);
        chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_wr     = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, n, 32'd2);
        chk({tag, ".rdata"}, resp_rdata, exp_rdata);
        chk({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, ".idle_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, ".idle_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_wr     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_funct3 = 3'd0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst.rdata", resp_rdata, 32'd0);
        chk("rst.err", {31'd0, resp_err}, 32'd0);
        chk("rst.state", {30'd0, dbg_state}, 32'd0);

        // Word store/load
        do_req("sw8", 1'b1, 32'h8, 32'hDEADBEEF, 3'd2, 32'd0, 1'b0);
        do_req("lw8", 1'b0, 32'h8, 32'd0, 3'd2, 32'hDEADBEEF, 1'b0);

        // Byte store, signed and unsigned byte loads
        do_req("sb9", 1'b1, 32'h9, 32'h00000080, 3'd0, 32'd0, 1'b0);
        do_req("lb9", 1'b0, 32'h9, 32'd0, 3'd0, 32'hFFFFFF80, 1'b0);
        do_req("lbu9", 1'b0, 32'h9, 32'd0, 3'd4, 32'h00000080, 1'b0);
        do_req("lw8b", 1'b0, 32'h8, 32'd0, 3'd2, 32'hDEAD80EF, 1'b0);
        do_req("lb8", 1'b0, 32'h8, 32'd0, 3'd0, 32'hFFFFFFEF, 1'b0);
        do_req("lbu11", 1'b0, 32'hB, 32'd0, 3'd4, 32'h000000DE, 1'b0);

        // Half store, signed and unsigned half loads
        do_req("shE", 1'b1, 32'hE, 32'h00008001, 3'd1, 32'd0, 1'b0);
        do_req("lhE", 1'b0, 32'hE, 32'd0, 3'd1, 32'hFFFF8001, 1'b0);
        do_req("lhuE", 1'b0, 32'hE, 32'd0, 3'd5, 32'h00008001, 1'b0);
        do_req("lwC", 1'b0, 32'hC, 32'd0, 3'd2, 32'h80010000, 1'b0);
        do_req("lhC", 1'b0, 32'hC, 32'd0, 3'd1, 32'h00000000, 1'b0);

        // Top word of the RAM
        do_req("sw7C", 1'b1, 32'h7C, 32'hA5A5A5A5, 3'd2, 32'd0, 1'b0);
        do_req("lw7C", 1'b0, 32'h7C, 32'd0, 3'd2, 32'hA5A5A5A5, 1'b0);

        // Error cases leave memory untouched
        do_req("sw4", 1'b1, 32'h4, 32'hCAFEF00D, 3'd2, 32'd0, 1'b0);
        do_req("e_lw6", 1'b0, 32'h6, 32'd0, 3'd2, 32'd0, 1'b1);
        do_req("e_lh3", 1'b0, 32'h3, 32'd0, 3'd1, 32'd0, 1'b1);
        do_req("e_lw80", 1'b0, 32'h80, 32'd0, 3'd2, 32'd0, 1'b1);
        do_req("e_f3", 1'b0, 32'h4, 32'd0, 3'd3, 32'd0, 1'b1);
        do_req("e_f7", 1'b0, 32'h4, 32'd0, 3'd7, 32'd0, 1'b1);
        do_req("e_sbu", 1'b1, 32'h4, 32'h00000011, 3'd4, 32'd0, 1'b1);
        do_req("e_shu", 1'b1, 32'h4, 32'h00002222, 3'd5, 32'd0, 1'b1);
        do_req("e_sw5", 1'b1, 32'h5, 32'h33333333, 3'd2, 32'd0, 1'b1);
        do_req("e_sw84", 1'b1, 32'h84, 32'h44444444, 3'd2, 32'd0, 1'b1);
        do_req("lw4", 1'b0, 32'h4, 32'd0, 3'd2, 32'hCAFEF00D, 1'b0);
        do_req("lw4_wrap", 1'b0, 32'h0, 32'd0, 3'd2, 32'h00000000, 1'b0);

        // Back-pressure: response held, extra request ignored
        @(negedge clk);
        req_valid  = 1'b1;
        req_wr     = 1'b0;
        req_addr   = 32'h8;
        req_funct3 = 3'd2;
        @(negedge clk);
        req_wr    = 1'b1;
        req_wdata = 32'h00000000;
        @(negedge clk);
        chk("bp.valid_rise", {31'd0, resp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp.hold%0d.valid", i), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("bp.hold%0d.rdata", i), resp_rdata, 32'hDEAD80EF);
            chk($sformatf("bp.hold%0d.ready", i), {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp.release.valid", {31'd0, resp_valid}, 32'd0);
        chk("bp.release.ready", {31'd0, req_ready}, 32'd1);
        do_req("bp.lw8", 1'b0, 32'h8, 32'd0, 3'd2, 32'hDEAD80EF, 1'b0);

        // Reset while a store is in WAIT: nothing committed, RAM cleared
        @(negedge clk);
        req_valid  = 1'b1;
        req_wr     = 1'b1;
        req_addr   = 32'h0;
        req_wdata  = 32'h12345678;
        req_funct3 = 3'd2;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mr.in_wait", {30'd0, dbg_state}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr.state", {30'd0, dbg_state}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mr.no_valid%0d", i), {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        do_req("mr.lw0", 1'b0, 32'h0, 32'd0, 3'd2, 32'h00000000, 1'b0);
        do_req("mr.lw8", 1'b0, 32'h8, 32'd0, 3'd2, 32'h00000000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
